// File: rtl/receiver.sv
// UART 8N1 receiver with 16x oversampling, ready/clear handshake, framing and overrun flags.
// Optional build macro: UART_RX_MAJORITY_EN selects 3-sample majority voting at decision points.
module receiver (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    input  logic       clken,
    input  logic       ready_clr,
    output logic [7:0] data,
    output logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_busy
);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e      state_q, state_d;
    logic [3:0]  sample_q, sample_d;
    logic [2:0]  bitpos_q, bitpos_d;
    logic [7:0]  scratch_q, scratch_d;
    logic [7:0]  data_q, data_d;
    logic        ready_q, ready_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q, overrun_d;
    logic        rx_meta_q, rx_s_q;
    logic        bit_val;

`ifdef UART_RX_MAJORITY_EN
    // Two previous samples; together with rx_s_q they form the 3-sample vote window.
    logic [1:0] hist_q, hist_d;

    assign bit_val = (rx_s_q & hist_q[0]) | (rx_s_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
    assign hist_d  = clken ? {hist_q[0], rx_s_q} : hist_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= hist_d;
        end
    end
`else
    assign bit_val = rx_s_q;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= StIdle;
            sample_q    <= 4'd0;
            bitpos_q    <= 3'd0;
            scratch_q   <= 8'h00;
            data_q      <= 8'h00;
            ready_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            state_q     <= state_d;
            sample_q    <= sample_d;
            bitpos_q    <= bitpos_d;
            scratch_q   <= scratch_d;
            data_q      <= data_d;
            ready_q     <= ready_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sample_d    = sample_q;
        bitpos_d    = bitpos_q;
        scratch_d   = scratch_q;
        data_d      = data_q;
        ready_d     = ready_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;

        // Clear first so that a flag set later in this block wins over a coincident clear.
        if (ready_clr) begin
            ready_d     = 1'b0;
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end

        if (clken) begin
            if (state_q != StIdle) begin
                sample_d = sample_q + 4'd1;
            end
            unique case (state_q)
                StIdle: begin
                    if (!rx_s_q) begin
                        state_d  = StStart;
                        sample_d = 4'd0;
                        bitpos_d = 3'd0;
                    end
                end
                StStart: begin
                    if (sample_q == 4'd7) begin
                        if (!bit_val) begin
                            state_d  = StData;
                            sample_d = 4'd0;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                StData: begin
                    if (sample_q == 4'd15) begin
                        scratch_d[bitpos_q] = bit_val;
                        if (bitpos_q == 3'd7) begin
                            state_d = StStop;
                        end else begin
                            bitpos_d = bitpos_q + 3'd1;
                        end
                    end
                end
                StStop: begin
                    if (sample_q == 4'd15) begin
                        if (bit_val) begin
                            data_d  = scratch_q;
                            ready_d = 1'b1;
                            if (ready_q && !ready_clr) begin
                                overrun_d = 1'b1;
                            end
                        end else begin
                            frame_err_d = 1'b1;
                        end
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign data      = data_q;
    assign ready     = ready_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign rx_busy   = (state_q != StIdle);

endmodule

// File: doc/receiver.md
# receiver

UART receive path: recovers 8N1 frames (one start bit, 8 data bits LSB first, one stop bit) from the serial `rx` line and presents each byte on a parallel port with a ready/clear handshake. Companion to the existing transmitter, driven from the same clock and the same baud generator, which supplies a 16× oversampling enable. Reports framing errors and overruns.

## Interface
- No parameters; frame format fixed at 8N1, oversampling fixed at 16×.
- `clock` input 1: system clock; all logic on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `rx` input 1: serial line, idle high, asynchronous to `clock`.
- `clken` input 1: single-cycle enable at 16× the baud rate.
- `ready_clr` input 1: consumer acknowledge; clears `ready`, `frame_err` and `overrun`.
- `data` output 8: last good received byte.
- `ready` output 1: a new byte is held in `data`.
- `frame_err` output 1: sticky; a stop bit was sampled low.
- `overrun` output 1: sticky; a good byte arrived while `ready` was already high.
- `rx_busy` output 1: high while a frame is in progress (state not IDLE).

## Operation
- `rx` passes through a 2-flop synchronizer (both flops reset to 1) to produce `rx_s`. All decisions use `rx_s`.
- Counters: 4-bit `sample`, incremented on every `clken` outside IDLE, wrapping 15→0. 3-bit `bitpos`. 8-bit shift scratch register.
- State machine, all transitions on `clken` only:
  - IDLE: `rx_s`==0 → START, `sample`<=0, `bitpos`<=0.
  - START: at `sample`==7 (mid start bit): if `rx_s`==0 → DATA, `sample`<=0; else → IDLE (glitch rejected, no flags).
  - DATA: at `sample`==15 (mid bit): scratch[`bitpos`]<=`rx_s`; `bitpos`==7 → STOP, else `bitpos`++.
  - STOP: at `sample`==15: `rx_s`==1 → `data`<=scratch, `ready`<=1, and `overrun`<=1 if `ready` was already 1 and `ready_clr` is low this cycle; `rx_s`==0 → `frame_err`<=1, `data` and `ready` unchanged. Both cases → IDLE.
- A new start bit is accepted on the first `clken` in IDLE after STOP (back-to-back frames supported).
- On overrun, `data` is overwritten with the newer byte.
- `ready_clr` is honoured in any state; clears `ready`, `frame_err` and `overrun` on the next edge. If it coincides with a set of any of these flags, the set wins.
- Reset values: `data`=8'h00, `ready`=0, `frame_err`=0, `overrun`=0, `rx_busy`=0, state IDLE, counters 0, scratch 0. Reset mid-frame aborts the frame with no flags set.

## Timing
- `rx` to `rx_s`: 2 `clock` cycles.
- Start edge to DATA: 8 `clken` ticks (1 detect + 7 in START). Each data bit and the stop bit: 16 ticks.
- `ready`/`frame_err` update on the edge where `clken` is high at STOP `sample`==15, i.e. ~9.5 bit times after the start edge plus the synchronizer delay.
- `rx_busy` rises on the edge that enters START and falls on the edge that returns to IDLE.
- With `clken` held low, all state is frozen.

## Configuration
- `UART_RX_MAJORITY_EN` defined: a 3-bit history of `rx_s` is shifted on every `clken`. Each decision point (start validation, data bits, stop bit) uses the majority of the current and previous two samples instead of `rx_s` alone. Idle start detection still uses the single `rx_s`.
- Not defined: single-sample decisions as described above; no history register.

## Test plan
- Send 0xA5 as 8N1 at 16× `clken` → `data`=0xA5, `ready`=1, `frame_err`=0, `overrun`=0; `ready_clr` pulse → `ready`=0.
- Drive `rx` low for 4 `clken` ticks, then high → stays IDLE, `rx_busy` drops, `ready`=0, `data`=0x00.
- Send 0x3C with the stop bit forced low → `frame_err`=1, `ready`=0, `data` unchanged; next frame 0x5A is received correctly.
- Send 0x11 then 0x22 back-to-back with no `ready_clr` → `data`=0x22, `ready`=1, `overrun`=1. Repeat with `ready_clr` coinciding with the second STOP sample → `ready`=1, `overrun`=0.
- Assert `reset` for 1 cycle after bit 3 of a frame → all outputs at reset values; a following frame 0xC3 yields `data`=0xC3.
- Send 0xFF with a 1-tick low glitch at mid-bit of bit 0 → `data`=0xFF with `UART_RX_MAJORITY_EN` defined, `data`=0xFE without it.
